// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and access sequencer for the shared RAM port
// Grants R0/R1 (round-robin or fixed priority), then runs the ENABLE/WAIT/DONE RAM sequence.
module mem_arbiter #(
  parameter int RAM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_R0_exec,
  input  logic        I_R0_write,
  input  logic [1:0]  I_R0_size,
  input  logic [15:0] I_R0_addr,
  input  logic [15:0] I_R0_data,
  output logic        O_R0_ready,
  output logic        O_R0_data_ready,
  output logic [15:0] O_R0_data,
  input  logic        I_R1_exec,
  input  logic        I_R1_write,
  input  logic [1:0]  I_R1_size,
  input  logic [15:0] I_R1_addr,
  input  logic [15:0] I_R1_data,
  output logic        O_R1_ready,
  output logic        O_R1_data_ready,
  output logic [15:0] O_R1_data,
  output logic        O_RAM_enable,
  output logic        O_RAM_write,
  output logic [1:0]  O_RAM_size,
  output logic [15:0] O_RAM_addr,
  output logic [15:0] O_RAM_data,
  input  logic [15:0] I_RAM_data,
  output logic        O_busy,
  output logic        O_grant
);

  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENABLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ram_enable, ram_enable_nxt;
  logic          ram_write, ram_write_nxt;
  logic [1:0]    ram_size, ram_size_nxt;
  logic [15:0]   ram_addr, ram_addr_nxt;
  logic [15:0]   ram_data, ram_data_nxt;
  logic          lat_write, lat_write_nxt;
  logic          grant, grant_nxt;
  logic          ready0, ready0_nxt, ready1, ready1_nxt;
  logic          dr0, dr0_nxt, dr1, dr1_nxt;
  logic [15:0]   data0, data0_nxt, data1, data1_nxt;
  logic          req0, req1, win;

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ram_enable <= 1'b0;
      ram_write  <= 1'b0;
      ram_size   <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      lat_write  <= 1'b0;
      grant      <= 1'b1;
      ready0     <= 1'b1;
      ready1     <= 1'b1;
      dr0        <= 1'b0;
      dr1        <= 1'b0;
      data0      <= '0;
      data1      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ram_enable <= ram_enable_nxt;
      ram_write  <= ram_write_nxt;
      ram_size   <= ram_size_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_data   <= ram_data_nxt;
      lat_write  <= lat_write_nxt;
      grant      <= grant_nxt;
      ready0     <= ready0_nxt;
      ready1     <= ready1_nxt;
      dr0        <= dr0_nxt;
      dr1        <= dr1_nxt;
      data0      <= data0_nxt;
      data1      <= data1_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ram_enable_nxt = ram_enable;
    ram_write_nxt  = ram_write;
    ram_size_nxt   = ram_size;
    ram_addr_nxt   = ram_addr;
    ram_data_nxt   = ram_data;
    lat_write_nxt  = lat_write;
    grant_nxt      = grant;
    ready0_nxt     = ready0;
    ready1_nxt     = ready1;
    dr0_nxt        = 1'b0;
    dr1_nxt        = 1'b0;
    data0_nxt      = data0;
    data1_nxt      = data1;
    req0           = 1'b0;
    req1           = 1'b0;
    win            = 1'b0;

    case (state)
      S_IDLE: begin
        req0 = I_R0_exec & ready0;
        req1 = I_R1_exec & ready1;
        // On a tie, round-robin favours whoever was not granted last.
        if (req0 && req1) win = (PRIORITY_MODE != 0) ? 1'b0 : ~grant;
        else              win = req1;
        if (req0 || req1) begin
          grant_nxt      = win;
          ram_enable_nxt = 1'b1;
          ram_write_nxt  = win ? I_R1_write : I_R0_write;
          lat_write_nxt  = win ? I_R1_write : I_R0_write;
          ram_size_nxt   = win ? I_R1_size  : I_R0_size;
          ram_addr_nxt   = win ? I_R1_addr  : I_R0_addr;
          ram_data_nxt   = win ? I_R1_data  : I_R0_data;
          if (win) ready1_nxt = 1'b0;
          else     ready0_nxt = 1'b0;
          state_nxt = S_ENABLE;
        end
      end
      S_ENABLE: begin
        ram_enable_nxt = 1'b0;
        ram_write_nxt  = 1'b0;
        cnt_nxt        = '0;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      S_DONE: begin
        // Read data is captured at the edge that closes DONE, alongside the pulse.
        if (grant) begin
          ready1_nxt = 1'b1;
          dr1_nxt    = 1'b1;
          if (!lat_write) data1_nxt = I_RAM_data;
        end else begin
          ready0_nxt = 1'b1;
          dr0_nxt    = 1'b1;
          if (!lat_write) data0_nxt = I_RAM_data;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign O_R0_ready      = ready0;
  assign O_R0_data_ready = dr0;
  assign O_R0_data       = data0;
  assign O_R1_ready      = ready1;
  assign O_R1_data_ready = dr1;
  assign O_R1_data       = data1;
  assign O_RAM_enable    = ram_enable;
  assign O_RAM_write     = ram_write;
  assign O_RAM_size      = ram_size;
  assign O_RAM_addr      = ram_addr;
  assign O_RAM_data      = ram_data;
  assign O_busy          = (state != S_IDLE);
  assign O_grant         = grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter
// Instance 0: RR, latency 1; instance 1: fixed priority, latency 1; instance 2: RR, latency 3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_exec, r0_write, r1_exec, r1_write;
  logic [1:0]  r0_size, r1_size;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata, ram_rdata;

  logic [2:0]  r0_ready, r0_dr, r1_ready, r1_dr, ram_en, ram_wr, busy, grant;
  logic [15:0] r0_data [3];
  logic [15:0] r1_data [3];
  logic [15:0] ram_addr [3];
  logic [15:0] ram_wdata [3];
  logic [1:0]  ram_size [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .RAM_LATENCY  ((g == 2) ? 3 : 1),
      .PRIORITY_MODE((g == 1) ? 1 : 0)
    ) u_dut (
      .I_clk          (clk),
      .I_reset        (rst_n),
      .I_R0_exec      (r0_exec),
      .I_R0_write     (r0_write),
      .I_R0_size      (r0_size),
      .I_R0_addr      (r0_addr),
      .I_R0_data      (r0_wdata),
      .O_R0_ready     (r0_ready[g]),
      .O_R0_data_ready(r0_dr[g]),
      .O_R0_data      (r0_data[g]),
      .I_R1_exec      (r1_exec),
      .I_R1_write     (r1_write),
      .I_R1_size      (r1_size),
      .I_R1_addr      (r1_addr),
      .I_R1_data      (r1_wdata),
      .O_R1_ready     (r1_ready[g]),
      .O_R1_data_ready(r1_dr[g]),
      .O_R1_data      (r1_data[g]),
      .O_RAM_enable   (ram_en[g]),
      .O_RAM_write    (ram_wr[g]),
      .O_RAM_size     (ram_size[g]),
      .O_RAM_addr     (ram_addr[g]),
      .O_RAM_data     (ram_wdata[g]),
      .I_RAM_data     (ram_rdata),
      .O_busy         (busy[g]),
      .O_grant        (grant[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_exec = 0; r0_write = 0; r0_size = 0; r0_addr = 0; r0_wdata = 0;
    r1_exec = 0; r1_write = 0; r1_size = 0; r1_addr = 0; r1_wdata = 0;
    ram_rdata = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({r0_ready[i], r1_ready[i], r0_dr[i], r1_dr[i], ram_en[i], ram_wr[i], busy[i], grant[i]} !== 8'b1100_0001) begin
        fails++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 11000001", i,
                 {r0_ready[i], r1_ready[i], r0_dr[i], r1_dr[i], ram_en[i], ram_wr[i], busy[i], grant[i]});
      end
      tests++;
      if ({r0_data[i], r1_data[i], ram_addr[i], ram_wdata[i], ram_size[i]} !== 66'd0) begin
        fails++;
        $display("FAIL reset_data[%0d]: got %h expected 0", i,
                 {r0_data[i], r1_data[i], ram_addr[i], ram_wdata[i], ram_size[i]});
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int n, en_cnt;
    do_reset();
    r0_addr = 16'h0010; r0_write = 1'b0; r0_size = 2'b01; r0_exec = 1'b1;
    tick();
    tests++;
    if ({ram_en[0], ram_wr[0], ram_addr[0], ram_size[0], r0_ready[0], grant[0], busy[0]} !== {2'b10, 16'h0010, 2'b01, 3'b001}) begin
      fails++;
      $display("FAIL read_enable: got en=%b wr=%b addr=%h size=%b rdy=%b gnt=%b busy=%b expected 1 0 0010 01 0 0 1",
               ram_en[0], ram_wr[0], ram_addr[0], ram_size[0], r0_ready[0], grant[0], busy[0]);
    end
    r0_exec = 1'b0;
    ram_rdata = 16'hBEEF;
    n = 0; en_cnt = 1;
    while (!r0_dr[0] && n < 20) begin
      tick();
      n++;
      if (ram_en[0]) en_cnt++;
    end
    tests++;
    if (n !== 3) begin fails++; $display("FAIL read_latency: got %0d expected 3", n); end
    tests++;
    if (en_cnt !== 1) begin fails++; $display("FAIL read_enable_width: got %0d expected 1", en_cnt); end
    tests++;
    if (r0_data[0] !== 16'hBEEF || r0_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL read_data: got data=%h ready=%b expected BEEF 1", r0_data[0], r0_ready[0]);
    end
    tick();
    tests++;
    if (r0_dr[0] !== 1'b0 || busy[0] !== 1'b0 || r0_data[0] !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_pulse_end: got dr=%b busy=%b data=%h expected 0 0 BEEF", r0_dr[0], busy[0], r0_data[0]);
    end
  endtask

  task automatic test_write();
    int n;
    logic r0_bad;
    do_reset();
    r1_addr = 16'h0300; r1_write = 1'b0; r1_exec = 1'b1; ram_rdata = 16'h5A5A;
    tick();
    r1_exec = 1'b0;
    n = 0;
    while (!r1_dr[0] && n < 20) begin tick(); n++; end
    tests++;
    if (r1_data[0] !== 16'h5A5A) begin fails++; $display("FAIL r1_read_data: got %h expected 5A5A", r1_data[0]); end
    tick();
    r1_addr = 16'h0200; r1_wdata = 16'h1234; r1_write = 1'b1; r1_size = 2'b10; r1_exec = 1'b1;
    tick();
    tests++;
    if ({ram_en[0], ram_wr[0], ram_addr[0], ram_wdata[0], grant[0], r1_ready[0]} !== {2'b11, 16'h0200, 16'h1234, 2'b10}) begin
      fails++;
      $display("FAIL write_enable: got en=%b wr=%b addr=%h data=%h gnt=%b rdy=%b expected 1 1 0200 1234 1 0",
               ram_en[0], ram_wr[0], ram_addr[0], ram_wdata[0], grant[0], r1_ready[0]);
    end
    r1_exec = 1'b0;
    ram_rdata = 16'hDEAD;
    tick();
    tests++;
    if (ram_en[0] !== 1'b0 || ram_wr[0] !== 1'b0) begin
      fails++;
      $display("FAIL write_strobe_clear: got en=%b wr=%b expected 0 0", ram_en[0], ram_wr[0]);
    end
    n = 1; r0_bad = 1'b0;
    while (!r1_dr[0] && n < 20) begin
      tick();
      n++;
      if (r0_dr[0] || !r0_ready[0]) r0_bad = 1'b1;
    end
    tests++;
    if (n !== 3) begin fails++; $display("FAIL write_latency: got %0d expected 3", n); end
    tests++;
    if (r1_data[0] !== 16'h5A5A) begin fails++; $display("FAIL write_data_kept: got %h expected 5A5A", r1_data[0]); end
    tests++;
    if (r0_bad !== 1'b0 || r0_data[0] !== 16'h0000) begin
      fails++;
      $display("FAIL write_r0_untouched: got bad=%b data=%h expected 0 0000", r0_bad, r0_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, cyc;
    logic [3:0] ord0, ord1;
    logic r1_seen;
    do_reset();
    r0_addr = 16'h00A0; r1_addr = 16'h00B0; r0_write = 1'b0; r1_write = 1'b0;
    r0_exec = 1'b1; r1_exec = 1'b1;
    c0 = 0; c1 = 0; cyc = 0; ord0 = '0; ord1 = '1; r1_seen = 1'b0;
    while ((c0 < 4 || c1 < 4) && cyc < 60) begin
      tick();
      cyc++;
      if (ram_en[0] && c0 < 4) begin ord0[c0] = grant[0]; c0++; end
      if (ram_en[1] && c1 < 4) begin ord1[c1] = grant[1]; c1++; end
      if (!r1_ready[1]) r1_seen = 1'b1;
    end
    r0_exec = 1'b0; r1_exec = 1'b0;
    tests++;
    if (c0 !== 4 || ord0 !== 4'b1010) begin
      fails++;
      $display("FAIL rr_order: got count=%0d order=%b expected 4 1010", c0, ord0);
    end
    tests++;
    if (c1 !== 4 || ord1 !== 4'b0000) begin
      fails++;
      $display("FAIL prio_order: got count=%0d order=%b expected 4 0000", c1, ord1);
    end
    tests++;
    if (r1_seen !== 1'b0) begin fails++; $display("FAIL prio_r1_starved: got %b expected 0", r1_seen); end
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    r0_addr = 16'h0044; r0_write = 1'b0; r0_exec = 1'b1; ram_rdata = 16'h1111;
    tick();
    r0_exec = 1'b0;
    n = 0;
    while (!r0_dr[2] && n < 20) begin
      tick();
      n++;
      if (n == 1) ram_rdata = 16'h2222;
      if (n == 4) ram_rdata = 16'h3333;
    end
    tests++;
    if (n !== 5) begin fails++; $display("FAIL lat3_latency: got %0d expected 5", n); end
    tests++;
    if (r0_data[2] !== 16'h3333) begin fails++; $display("FAIL lat3_capture: got %h expected 3333", r0_data[2]); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic dr_seen;
    do_reset();
    r0_addr = 16'h0020; r0_write = 1'b0; r0_exec = 1'b1; ram_rdata = 16'h7777;
    tick();
    r0_exec = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({r0_ready[0], r1_ready[0], r0_dr[0], ram_en[0], busy[0], grant[0]} !== 6'b110001 || ram_addr[0] !== 16'h0000) begin
      fails++;
      $display("FAIL async_reset: got ctrl=%b addr=%h expected 110001 0000",
               {r0_ready[0], r1_ready[0], r0_dr[0], ram_en[0], busy[0], grant[0]}, ram_addr[0]);
    end
    dr_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (r0_dr[0] || r1_dr[0]) dr_seen = 1'b1; end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); if (r0_dr[0] || r1_dr[0] || busy[0]) dr_seen = 1'b1; end
    tests++;
    if (dr_seen !== 1'b0) begin fails++; $display("FAIL reset_no_pulse: got %b expected 0", dr_seen); end
    r1_addr = 16'h0555; r1_write = 1'b0; r1_exec = 1'b1; ram_rdata = 16'h0ABC;
    tick();
    tests++;
    if (ram_en[0] !== 1'b1 || grant[0] !== 1'b1 || ram_addr[0] !== 16'h0555) begin
      fails++;
      $display("FAIL post_reset_grant: got en=%b gnt=%b addr=%h expected 1 1 0555", ram_en[0], grant[0], ram_addr[0]);
    end
    r1_exec = 1'b0;
    n = 0;
    while (!r1_dr[0] && n < 20) begin tick(); n++; end
    tests++;
    if (n !== 3 || r1_data[0] !== 16'h0ABC) begin
      fails++;
      $display("FAIL post_reset_read: got lat=%0d data=%h expected 3 0ABC", n, r1_data[0]);
    end
  endtask

  task automatic test_withdrawn();
    logic r1_bad, r0_done;
    do_reset();
    r0_addr = 16'h0030; r0_write = 1'b0; r0_exec = 1'b1; ram_rdata = 16'h4242;
    tick();
    r0_exec = 1'b0;
    r1_addr = 16'h0031; r1_exec = 1'b1;
    r1_bad = ~r1_ready[0];
    tick();
    r1_exec = 1'b0;
    r0_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!r1_ready[0] || r1_dr[0] || (ram_en[0] && grant[0])) r1_bad = 1'b1;
      if (r0_dr[0]) r0_done = 1'b1;
      tick();
    end
    tests++;
    if (r1_bad !== 1'b0) begin fails++; $display("FAIL withdrawn_r1: got %b expected 0", r1_bad); end
    tests++;
    if (r0_done !== 1'b1 || r0_data[0] !== 16'h4242) begin
      fails++;
      $display("FAIL withdrawn_r0_done: got done=%b data=%h expected 1 4242", r0_done, r0_data[0]);
    end
    tests++;
    if (grant[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL withdrawn_idle: got gnt=%b busy=%b expected 0 0", grant[0], busy[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared RAM port.
- Requester 0 is the core memory interface. Requester 1 is a secondary master, such as a UART boot loader or DMA engine.
- Each requester uses the core's MEM handshake: exec/ready/data_ready.
- The block grants one requester at a time, drives the RAM enable/write/size/addr/data sequence, waits the RAM read latency, and returns data with a one-cycle data_ready pulse.

Parameters:
- RAM_LATENCY, 1, cycles from RAM enable deassertion to valid I_RAM_data; legal range ≥1.
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 0 wins.

Ports:
- I_clk  in  1  system clock, all logic on rising edge
- I_reset  in  1  asynchronous, active-low reset
- I_R0_exec  in  1  requester 0 command valid; held until O_R0_ready falls
- I_R0_write  in  1  1 = write, 0 = read
- I_R0_size  in  2  access size, passed through to RAM
- I_R0_addr  in  16  address
- I_R0_data  in  16  write data
- O_R0_ready  out  1  1 = no R0 transaction in flight
- O_R0_data_ready  out  1  one-cycle completion pulse
- O_R0_data  out  16  read data, valid from the data_ready pulse until the next R0 read completes
- I_R1_exec, I_R1_write, I_R1_size, I_R1_addr, I_R1_data, O_R1_ready, O_R1_data_ready, O_R1_data  as R0, for requester 1
- O_RAM_enable  out  1  RAM enable
- O_RAM_write  out  1  RAM write strobe
- O_RAM_size  out  2  RAM access size
- O_RAM_addr  out  16  RAM address
- O_RAM_data  out  16  RAM write data
- I_RAM_data  in  16  RAM read data
- O_busy  out  1  1 when state ≠ IDLE
- O_grant  out  1  index of the requester currently or last granted

Behaviour:
- Reset (I_reset=0, asynchronous):
  - state=IDLE.
  - O_Rn_ready=1, O_Rn_data_ready=0, O_Rn_data=0.
  - All O_RAM_* outputs = 0.
  - O_busy=0, O_grant=1, so R0 wins the first tie in round-robin.
  - Reset mid-transaction abandons the access; no data_ready is issued.
- States: IDLE, ENABLE, WAIT, DONE.
- IDLE, request sampling:
  - On each edge, sample I_Rn_exec where O_Rn_ready=1.
  - With one request, grant it.
  - With both requests:
    - PRIORITY_MODE=0: grant the requester ≠ O_grant.
    - PRIORITY_MODE=1: grant R0.
- IDLE, on grant:
  - Latch write/size/addr/data of the winner into the O_RAM_* registers.
  - O_grant ← winner; O_Rwinner_ready ← 0; go to ENABLE.
  - The loser's ready stays 1 and its request stays pending.
- ENABLE (1 cycle): O_RAM_enable=1, O_RAM_write=latched write; then go to WAIT.
- WAIT:
  - O_RAM_enable=0 and O_RAM_write=0.
  - Count RAM_LATENCY cycles, then go to DONE.
- DONE (1 cycle):
  - For a read, O_Rg_data ← I_RAM_data.
  - For a write, O_Rg_data is unchanged.
  - O_Rg_data_ready=1 for exactly this cycle, and O_Rg_ready ← 1.
  - Go to IDLE.
- Latency: exec sampled at edge k gives O_data_ready high in cycle k+2+RAM_LATENCY, and the next grant occurs at the edge ending DONE+1 (IDLE). Throughput is one access per RAM_LATENCY+3 cycles.
- Request handling rules:
  - An exec deasserted before grant is a withdrawn request; no side effects.
  - Exec while own ready=0 is ignored.
  - Requester inputs are sampled only at grant; later changes do not affect the transaction.
- Fairness: in round-robin mode, with both exec held continuously, grants strictly alternate R0, R1, R0, …
- Address decoding (UART, bootrom) is outside this block; all granted accesses go to the RAM port.

Test Plan:
- R0 read, addr=0x0010, RAM returns 0xBEEF, RAM_LATENCY=1 → O_RAM_enable high for 1 cycle with addr 0x0010 and write=0; O_R0_data_ready pulses 3 cycles after accept; O_R0_data=0xBEEF; O_R0_ready=1.
- R1 write, addr=0x0200, data=0x1234 → O_RAM_write=1 with O_RAM_data=0x1234 during ENABLE; O_R1_data_ready pulses; O_R1_data unchanged; R0 outputs untouched.
- Both exec asserted in the same cycle after reset, held continuously for 4 transactions → grant order R0, R1, R0, R1; O_grant toggles. With PRIORITY_MODE=1 → R0 served four times, R1 never granted.
- RAM_LATENCY=3, R0 read → data_ready 5 cycles after accept; I_RAM_data sampled only in DONE (bench changes I_RAM_data in WAIT and checks the final value is captured).
- I_reset driven low asynchronously during WAIT → all outputs return to reset values immediately, with no data_ready. After release, a new R1 request is accepted normally.
- R1 exec pulsed for 1 cycle while R0 is busy, then dropped → no R1 grant occurs. O_R1_ready stays 1 throughout.
